axi_rd_arbiter: RTL and testbench
=================================

# axi_rd_arbiter

Two-master arbiter that shares one AXI4-Lite read port (read address and read data channels only) of the `sram_axi` / `bram_axi` memory bridge between two requesters, e.g. `uart_debug` on master 0 and a second reader on master 1. It sits between the requesters' `ar`/`r` channels and the bridge's `ar_*`/`r_*` ports. It allows exactly one outstanding read at a time and routes each response back to the master that issued the request.

## Interface
- `ADDR_W`, default 18: read address width.
- `DATA_W`, default 16: read data width.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous reset, active-high.
- `s0_ar_addr` / `s1_ar_addr` in ADDR_W: read address from master 0 / master 1.
- `s0_ar_valid` / `s1_ar_valid` in 1: address valid from each master.
- `s0_ar_ready` / `s1_ar_ready` out 1: address accepted, one per master.
- `s0_r_data` / `s1_r_data` out DATA_W: read data to each master.
- `s0_r_resp` / `s1_r_resp` out 2: read response to each master.
- `s0_r_valid` / `s1_r_valid` out 1: read data valid, one per master.
- `s0_r_ready` / `s1_r_ready` in 1: read data ready from each master.
- `m_ar_addr` out ADDR_W: address to the memory bridge.
- `m_ar_valid` out 1: address valid to the bridge.
- `m_ar_ready` in 1: address ready from the bridge.
- `m_r_data` in DATA_W: read data from the bridge.
- `m_r_resp` in 2: read response from the bridge.
- `m_r_valid` in 1: read data valid from the bridge.
- `m_r_ready` out 1: read data ready to the bridge.

## Operation
- FSM states: IDLE, ADDR, DATA. State register, `grant`, `last_grant` and `addr_q` are all registered.
- IDLE, arbitration:
  - Only s0 valid: master 0 wins. Only s1 valid: master 1 wins.
  - Both valid: the master not equal to `last_grant` wins.
  - The winner's `sN_ar_ready` is driven high combinationally in that cycle, completing its address handshake.
  - On that edge: `addr_q <= sN_ar_addr`, `grant <= N`, state goes to ADDR.
- ADDR:
  - `m_ar_valid=1` and `m_ar_addr=addr_q`, held stable until `m_ar_ready`.
  - On `m_ar_valid && m_ar_ready`, state goes to DATA.
- DATA, response routing:
  - `s[grant]_r_valid = m_r_valid`; `s[grant]_r_data` and `s[grant]_r_resp` pass through from the bridge.
  - `m_r_ready = s[grant]_r_ready`.
  - On `m_r_valid && m_r_ready`: `last_grant <= grant`, state goes to IDLE.
- The losing master's `ar_valid` stays pending; it is served no earlier than the IDLE cycle following completion.
- The non-granted master always sees `r_valid=0`. Both `sN_r_data` outputs carry `m_r_data` unconditionally; only `r_valid` is gated.
- Both `ar_ready` outputs are 0 in ADDR and DATA.
- `m_r_ready=0` outside DATA. A `m_r_valid` arriving outside DATA is not consumed.

## Timing
- Reset values: state=IDLE, `last_grant=1` (master 0 wins the first tie), `grant=0`, `addr_q=0`, `m_ar_valid=0`, `m_r_ready=0`, all `sN_ar_ready=0`, all `sN_r_valid=0`. While `rst=1`, all ready/valid outputs are forced to 0.
- Latency:
  - Master handshake in cycle T gives `m_ar_valid` in cycle T+1.
  - With a zero-wait bridge (`m_ar_ready=1`), DATA is entered at T+2.
  - The response passes through combinationally, with zero added latency.
  - Next arbitration happens at the earliest in the cycle after the r handshake. Throughput is at most one read per 3 cycles.
- Reset asserted in ADDR or DATA: the transaction is abandoned, state returns to IDLE, and no `r_valid` is delivered to either master. The bridge must be reset alongside.
- A master that drops `ar_valid` before being granted is not served. Masters are required to hold valid; the block does not check this.

## Configuration
- Macro `AXI_RD_ARB_RR_EN`.
- Defined: round-robin tie-break using `last_grant`, as described above.
- Undefined: fixed priority, where master 0 always wins a tie. `last_grant` is not implemented, and master 1 can starve while master 0 holds `ar_valid` continuously.

## Test plan
- Single read, zero-wait bridge (`bram_axi`): s0 reads 18'h37648, bridge returns 16'h7648 -> `s0_ar_ready` at T, `m_ar_valid` at T+1, `s0_r_valid` with 16'h7648, `s1_r_valid` never high.
- Simultaneous: s0 requests 18'h00000 and s1 requests 18'h3ffff at the same cycle after reset -> s0 is served first, then s1. `s1_r_data`=16'hffff while `s1_r_valid`=1; `s0_r_valid` stays 0 throughout s1's response.
- Continuous contention: both masters hold valid for 8 reads -> grants alternate 0,1,0,1… with `AXI_RD_ARB_RR_EN` defined; with it undefined, all 8 grants go to master 0 while s0 is held valid.
- Back-pressure: `m_ar_ready` low for 5 cycles, then `s1_r_ready` low for 4 cycles with `m_r_valid` high -> `m_ar_addr` stays stable at 18'h1aa55, no new grant is issued, data is delivered once.
- Reset mid-DATA: assert `rst` for 1 cycle while `m_r_valid=0` -> all outputs return to reset values, and the next s0 read of 18'h00001 completes normally.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI4-Lite read port (AR + R channels) of the
// memory bridge between two requesters. It allows one outstanding read at a
// time and routes the response back to the master that issued it.
//
// Configuration macro: AXI_RD_ARB_RR_EN
//   defined   -> round-robin tie-break using last_grant
//   undefined -> fixed priority, master 0 wins every tie
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   s0_ar_* / s1_ar_*             read address channel from master 0 / 1
//   s0_r_*  / s1_r_*              read data channel to master 0 / 1
//   m_ar_*                        read address channel to the bridge
//   m_r_*                         read data channel from the bridge
module axi_rd_arbiter #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s0_ar_addr,
  input  logic              s0_ar_valid,
  output logic              s0_ar_ready,
  output logic [DATA_W-1:0] s0_r_data,
  output logic [1:0]        s0_r_resp,
  output logic              s0_r_valid,
  input  logic              s0_r_ready,
  input  logic [ADDR_W-1:0] s1_ar_addr,
  input  logic              s1_ar_valid,
  output logic              s1_ar_ready,
  output logic [DATA_W-1:0] s1_r_data,
  output logic [1:0]        s1_r_resp,
  output logic              s1_r_valid,
  input  logic              s1_r_ready,
  output logic [ADDR_W-1:0] m_ar_addr,
  output logic              m_ar_valid,
  input  logic              m_ar_ready,
  input  logic [DATA_W-1:0] m_r_data,
  input  logic [1:0]        m_r_resp,
  input  logic              m_r_valid,
  output logic              m_r_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              tie_win;
  logic              win;
  logic              gr_r_ready;

`ifdef AXI_RD_ARB_RR_EN
  logic last_grant_q, last_grant_d;

  // On a tie, the master that was not served last goes next
  assign tie_win = ~last_grant_q;
`else
  logic unused_last;

  // Fixed priority: master 0 always wins a tie
  assign tie_win     = 1'b0;
  assign unused_last = 1'b0;
`endif

  // Winner index: a lone requester always wins, a tie uses tie_win
  assign win = (s0_ar_valid && s1_ar_valid) ? tie_win : s1_ar_valid;

  // r_ready of the master that owns the outstanding read
  assign gr_r_ready = grant_q ? s1_r_ready : s0_r_ready;

  // Read data and response pass straight through; only r_valid is steered
  assign s0_r_data = m_r_data;
  assign s1_r_data = m_r_data;
  assign s0_r_resp = m_r_resp;
  assign s1_r_resp = m_r_resp;

  // State and transaction registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      addr_q       <= '0;
`ifdef AXI_RD_ARB_RR_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
`ifdef AXI_RD_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
`ifdef AXI_RD_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    s0_ar_ready  = 1'b0;
    s1_ar_ready  = 1'b0;
    m_ar_valid   = 1'b0;
    m_ar_addr    = addr_q;
    m_r_ready    = 1'b0;
    s0_r_valid   = 1'b0;
    s1_r_valid   = 1'b0;

    case (state_q)
      IDLE: begin
        if (s0_ar_valid || s1_ar_valid) begin
          s0_ar_ready = ~win;
          s1_ar_ready = win;
          addr_d      = win ? s1_ar_addr : s0_ar_addr;
          grant_d     = win;
          state_d     = ADDR;
        end
      end
      ADDR: begin
        m_ar_valid = 1'b1;
        if (m_ar_ready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        m_r_ready  = gr_r_ready;
        s0_r_valid = m_r_valid && !grant_q;
        s1_r_valid = m_r_valid && grant_q;
        if (m_r_valid && gr_r_ready) begin
`ifdef AXI_RD_ARB_RR_EN
          last_grant_d = grant_q;
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake outputs stay quiet for the whole reset cycle
    if (rst) begin
      s0_ar_ready = 1'b0;
      s1_ar_ready = 1'b0;
      m_ar_valid  = 1'b0;
      m_r_ready   = 1'b0;
      s0_r_valid  = 1'b0;
      s1_r_valid  = 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: scoreboard bench for axi_rd_arbiter with two queue-driven
// masters, a bridge model with programmable stalls, and a per-cycle monitor.
module tb_axi_rd_arbiter;

  localparam int unsigned ADDR_W = 18;
  localparam int unsigned DATA_W = 16;

  typedef struct packed {
    logic              m;
    logic [DATA_W-1:0] d;
    logic [1:0]        r;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] s0_ar_addr, s1_ar_addr, m_ar_addr;
  logic              s0_ar_valid, s1_ar_valid, s0_ar_ready, s1_ar_ready;
  logic [DATA_W-1:0] s0_r_data, s1_r_data, m_r_data;
  logic [1:0]        s0_r_resp, s1_r_resp, m_r_resp;
  logic              s0_r_valid, s1_r_valid, s0_r_ready, s1_r_ready;
  logic              m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;

  axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .s0_ar_addr(s0_ar_addr), .s0_ar_valid(s0_ar_valid), .s0_ar_ready(s0_ar_ready),
    .s0_r_data(s0_r_data), .s0_r_resp(s0_r_resp), .s0_r_valid(s0_r_valid), .s0_r_ready(s0_r_ready),
    .s1_ar_addr(s1_ar_addr), .s1_ar_valid(s1_ar_valid), .s1_ar_ready(s1_ar_ready),
    .s1_r_data(s1_r_data), .s1_r_resp(s1_r_resp), .s1_r_valid(s1_r_valid), .s1_r_ready(s1_r_ready),
    .m_ar_addr(m_ar_addr), .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_valid(m_r_valid), .m_r_ready(m_r_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stimulus queues, scoreboard and logs
  logic [ADDR_W-1:0] q0[$], q1[$];
  exp_t              sb[$];
  int                glog[$], ac_log[$], dv_log[$];

  // Stall and delay counters for the bridge and masters
  int ar_block = 0, r_delay = 0, r0_block = 0, r1_block = 0;

  // Reference model state
  int                mstate = 0, mgrant = 0, mlast = 1;
  logic [ADDR_W-1:0] exp_addr;
  int                cyc = 0, t_hs = 0, t_mav = 0, t_rv = 0;
  int                addr_cycles = 0, data_cycles = 0, data_vcycles = 0;
  int                n_deliv = 0, s1_rv_seen = 0;
  logic [DATA_W-1:0] last_data;

  // Values sampled at the falling edge for the driver half
  logic              rst_s, ar_hs_s, r_hs_s, hs0_s, hs1_s, mav_s, rv0_s, rv1_s;
  logic [ADDR_W-1:0] ar_addr_s;

  // Bridge model state
  logic pend = 1'b0;
  int   rd_cnt = 0;

  task automatic monitor();
    logic [1:0] er;
    int         w;
    exp_t       e;
    cyc++;
    rst_s     = rst;
    ar_hs_s   = m_ar_valid && m_ar_ready;
    r_hs_s    = m_r_valid && m_r_ready;
    hs0_s     = s0_ar_valid && s0_ar_ready;
    hs1_s     = s1_ar_valid && s1_ar_ready;
    mav_s     = m_ar_valid;
    rv0_s     = s0_r_valid;
    rv1_s     = s1_r_valid;
    ar_addr_s = m_ar_addr;
    if (rst) begin
      check_eq("rst_outs", 32'({s1_ar_ready, s0_ar_ready, m_ar_valid, m_r_ready, s1_r_valid, s0_r_valid}), 0);
      mstate = 0; mlast = 1; sb.delete();
      ar_hs_s = 1'b0; r_hs_s = 1'b0; hs0_s = 1'b0; hs1_s = 1'b0;
      return;
    end
    if (s1_r_valid) s1_rv_seen++;
    check_eq("r_data_pass", 32'({s1_r_data, s0_r_data}), 32'({m_r_data, m_r_data}));
    case (mstate)
      0: begin
`ifdef AXI_RD_ARB_RR_EN
        w = (s0_ar_valid && s1_ar_valid) ? ((mlast == 0) ? 1 : 0) : int'(s1_ar_valid);
`else
        w = (s0_ar_valid && s1_ar_valid) ? 0 : int'(s1_ar_valid);
`endif
        er = (s0_ar_valid || s1_ar_valid) ? ((w == 1) ? 2'b10 : 2'b01) : 2'b00;
        check_eq("idle_ar_ready", 32'({s1_ar_ready, s0_ar_ready}), 32'(er));
        check_eq("idle_quiet", 32'({m_ar_valid, m_r_ready, s1_r_valid, s0_r_valid}), 0);
        if (s0_ar_valid || s1_ar_valid) begin
          mgrant   = w;
          exp_addr = (w == 1) ? s1_ar_addr : s0_ar_addr;
          e.m = (w == 1);
          e.d = DATA_W'(exp_addr);
          e.r = exp_addr[ADDR_W-1 -: 2];
          sb.push_back(e);
          glog.push_back(w);
          t_hs = cyc; t_mav = 0; t_rv = 0;
          addr_cycles = 0; data_cycles = 0; data_vcycles = 0;
          mstate = 1;
        end
      end
      1: begin
        check_eq("addr_ar_ready", 32'({s1_ar_ready, s0_ar_ready}), 0);
        check_eq("addr_m_ar_valid", 32'(m_ar_valid), 1);
        check_eq("addr_m_ar_addr", 32'(m_ar_addr), 32'(exp_addr));
        check_eq("addr_quiet", 32'({m_r_ready, s1_r_valid, s0_r_valid}), 0);
        addr_cycles++;
        if (t_mav == 0) t_mav = cyc;
        if (m_ar_ready) mstate = 2;
      end
      default: begin
        check_eq("data_ar_ready", 32'({s1_ar_ready, s0_ar_ready, m_ar_valid}), 0);
        er = m_r_valid ? ((mgrant == 1) ? 2'b10 : 2'b01) : 2'b00;
        check_eq("data_r_valid", 32'({s1_r_valid, s0_r_valid}), 32'(er));
        check_eq("data_m_r_ready", 32'(m_r_ready), 32'((mgrant == 1) ? s1_r_ready : s0_r_ready));
        data_cycles++;
        if (m_r_valid) begin
          data_vcycles++;
          if (t_rv == 0) t_rv = cyc;
        end
        if (m_r_valid && ((mgrant == 1) ? s1_r_ready : s0_r_ready)) begin
          check_eq("sb_nonempty", 32'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq("r_master", 32'(s1_r_valid), 32'(e.m));
            check_eq("r_data", 32'(s1_r_valid ? s1_r_data : s0_r_data), 32'(e.d));
            check_eq("r_resp", 32'(s1_r_valid ? s1_r_resp : s0_r_resp), 32'(e.r));
          end
          last_data = m_r_data;
          n_deliv++;
          ac_log.push_back(addr_cycles);
          dv_log.push_back(data_vcycles);
          mlast  = mgrant;
          mstate = 0;
        end
      end
    endcase
  endtask

  task automatic drive();
    // Bridge: address stall counter, response delay counter
    if (mav_s && ar_block > 0) ar_block--;
    m_ar_ready = (ar_block == 0);
    if (rst_s) begin
      pend = 1'b0; m_r_valid = 1'b0; rd_cnt = 0;
    end else begin
      if (r_hs_s) begin
        m_r_valid = 1'b0; pend = 1'b0;
      end
      if (ar_hs_s) begin
        pend     = 1'b1;
        rd_cnt   = r_delay;
        m_r_data = DATA_W'(ar_addr_s);
        m_r_resp = ar_addr_s[ADDR_W-1 -: 2];
      end
      if (pend && !m_r_valid) begin
        if (rd_cnt == 0) m_r_valid = 1'b1;
        else rd_cnt--;
      end
    end
    // Masters: hold valid until accepted, then present the next address
    if (hs0_s && q0.size() != 0) void'(q0.pop_front());
    if (hs1_s && q1.size() != 0) void'(q1.pop_front());
    s0_ar_valid = (q0.size() != 0);
    s1_ar_valid = (q1.size() != 0);
    s0_ar_addr  = (q0.size() != 0) ? q0[0] : '0;
    s1_ar_addr  = (q1.size() != 0) ? q1[0] : '0;
    if (rv0_s && r0_block > 0) r0_block--;
    if (rv1_s && r1_block > 0) r1_block--;
    s0_r_ready = (r0_block == 0);
    s1_r_ready = (r1_block == 0);
  endtask

  initial begin : env
    s0_ar_valid = 1'b0; s1_ar_valid = 1'b0; s0_ar_addr = '0; s1_ar_addr = '0;
    s0_r_ready = 1'b1; s1_r_ready = 1'b1;
    m_ar_ready = 1'b1; m_r_valid = 1'b0; m_r_data = '0; m_r_resp = '0;
    forever begin
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      drive();
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic reset_pulse();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    glog.delete(); ac_log.delete(); dv_log.delete();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || sb.size() != 0 || mstate != 0) && n < budget) begin
      step();
      n++;
    end
    check_eq("drain_in_time", 32'(n < budget), 1);
    step();
  endtask

  initial begin : main
    int d0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;
    step();
    check_eq("reset_outs", 32'({s1_ar_ready, s0_ar_ready, m_ar_valid, m_r_ready, s1_r_valid, s0_r_valid}), 0);
    check_eq("reset_addr", 32'(m_ar_addr), 0);

    // Single read through a zero-wait bridge
    clear_logs(); s1_rv_seen = 0;
    q0.push_back(18'h37648);
    drain(100);
    check_eq("t1_grants", 32'(glog.size()), 1);
    if (glog.size() == 1) check_eq("t1_grant0", 32'(glog[0]), 0);
    check_eq("t1_mav_lat", 32'(t_mav - t_hs), 1);
    check_eq("t1_rv_lat", 32'(t_rv - t_hs), 2);
    check_eq("t1_s1_rv", 32'(s1_rv_seen), 0);
    check_eq("t1_data", 32'(last_data), 32'h7648);

    // Simultaneous requests right after reset
    reset_pulse();
    clear_logs();
    q0.push_back(18'h00000);
    q1.push_back(18'h3ffff);
    drain(100);
    check_eq("t2_grants", 32'(glog.size()), 2);
    if (glog.size() == 2) begin
      check_eq("t2_first", 32'(glog[0]), 0);
      check_eq("t2_second", 32'(glog[1]), 1);
    end
    check_eq("t2_data", 32'(last_data), 32'hffff);

    // Continuous contention
    reset_pulse();
    clear_logs();
    for (int i = 0; i < 8; i++) begin
      q0.push_back(ADDR_W'(32'h00010 + i));
      q1.push_back(ADDR_W'(32'h20000 + i));
    end
    drain(1000);
    check_eq("t3_grants", 32'(glog.size()), 16);
    for (int i = 0; i < 8 && i < glog.size(); i++) begin
`ifdef AXI_RD_ARB_RR_EN
      check_eq("t3_grant_rr", 32'(glog[i]), 32'(i % 2));
`else
      check_eq("t3_grant_fixed", 32'(glog[i]), 0);
`endif
    end

    // Back-pressure on both bridge channels
    clear_logs();
    d0 = n_deliv;
    ar_block = 5;
    r1_block = 4;
    q1.push_back(18'h1aa55);
    step();
    q0.push_back(18'h00abc);
    drain(200);
    check_eq("t4_deliv", 32'(n_deliv - d0), 2);
    check_eq("t4_grants", 32'(glog.size()), 2);
    if (glog.size() == 2) begin
      check_eq("t4_first", 32'(glog[0]), 1);
      check_eq("t4_second", 32'(glog[1]), 0);
    end
    if (ac_log.size() != 0) check_eq("t4_addr_cycles", 32'(ac_log[0]), 6);
    if (dv_log.size() != 0) check_eq("t4_rvalid_cycles", 32'(dv_log[0]), 5);

    // Reset while waiting for read data
    clear_logs();
    d0 = n_deliv;
    r_delay = 3;
    q0.push_back(18'h00123);
    begin
      int n = 0;
      while (!(mstate == 2 && data_cycles >= 1) && n < 100) begin
        step();
        n++;
      end
      check_eq("t5_reach_data", 32'(n < 100), 1);
    end
    reset_pulse();
    step();
    check_eq("t5_outs", 32'({s1_ar_ready, s0_ar_ready, m_ar_valid, m_r_ready, s1_r_valid, s0_r_valid}), 0);
    check_eq("t5_addr", 32'(m_ar_addr), 0);
    repeat (4) step();
    check_eq("t5_no_deliv", 32'(n_deliv - d0), 0);
    r_delay = 0;
    q0.push_back(18'h00001);
    drain(100);
    check_eq("t5_deliv", 32'(n_deliv - d0), 1);
    check_eq("t5_data", 32'(last_data), 32'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
